// File: rtl/serial_comp_ctrl.sv
// rtl/serial_comp_ctrl.sv - word-serial complement sequencer, LSB first, one word in flight
// Optional feature macro: TWOS_COMP_EN (adds mode port and two's complement cell)
module serial_comp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
`ifdef TWOS_COMP_EN
  input  logic             mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             busy,
  output logic             ser_en,
  output logic             ser_bit
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  logic             last_bit;
  logic             cell_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef TWOS_COMP_EN
  logic mode_q;
  logic seen_one;

  // Two's complement: pass bits through up to and including the first 1, invert after.
  always_comb begin
    cell_bit = ~operand[0];
    if (mode_q && !seen_one)
      cell_bit = operand[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= 1'b0;
      seen_one <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      mode_q   <= mode;
      seen_one <= 1'b0;
    end else if (state == SHIFT) begin
      seen_one <= seen_one | operand[0];
    end
  end
`else
  assign cell_bit = ~operand[0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    ser_en    = 1'b0;
    ser_bit   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        ser_en  = 1'b1;
        ser_bit = operand[0];
        if (last_bit)
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // out_word is a separate register so the previous result stays visible while the next word shifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      operand  <= '0;
      result   <= '0;
      out_word <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            operand <= in_word;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          operand <= operand >> 1;
          result  <= {cell_bit, result[WIDTH-1:1]};
          cnt     <= cnt + CW'(1);
          if (last_bit)
            out_word <= {cell_bit, result[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// tb/tb_serial_comp_ctrl.sv - scoreboard bench for serial_comp_ctrl at WIDTH 8, 2 and 32
module tb_serial_comp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [7:0]  in_word = '0, out_word;
  logic        busy, ser_en, ser_bit;
`ifdef TWOS_COMP_EN
  logic        mode8 = 1'b0;
  logic        mode_n = 1'b0;
`endif

  logic        w2_valid = 1'b0, w2_ready, w2_ov, w2_or = 1'b1, w2_busy, w2_se, w2_sb;
  logic [1:0]  w2_word = '0, w2_out;
  logic        w32_valid = 1'b0, w32_ready, w32_ov, w32_or = 1'b1, w32_busy, w32_se, w32_sb;
  logic [31:0] w32_word = '0, w32_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  serial_comp_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
`ifdef TWOS_COMP_EN
    .mode(mode8),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .busy(busy), .ser_en(ser_en), .ser_bit(ser_bit)
  );

  serial_comp_ctrl #(.WIDTH(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .in_valid(w2_valid), .in_ready(w2_ready), .in_word(w2_word),
`ifdef TWOS_COMP_EN
    .mode(mode_n),
`endif
    .out_valid(w2_ov), .out_ready(w2_or), .out_word(w2_out),
    .busy(w2_busy), .ser_en(w2_se), .ser_bit(w2_sb)
  );

  serial_comp_ctrl #(.WIDTH(32)) u_dut_w32 (
    .clk(clk), .rst(rst), .in_valid(w32_valid), .in_ready(w32_ready), .in_word(w32_word),
`ifdef TWOS_COMP_EN
    .mode(mode_n),
`endif
    .out_valid(w32_ov), .out_ready(w32_or), .out_word(w32_out),
    .busy(w32_busy), .ser_en(w32_se), .ser_bit(w32_sb)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model8(input logic [7:0] w, input logic m);
    logic [7:0] r;
    r = ~w;
    if (m)
      r = r + 8'd1;
    return r;
  endfunction

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_word"},  32'(out_word),  32'd0);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_ser_en"},    32'(ser_en),    32'd0);
    check_eq({tag, "_ser_bit"},   32'(ser_bit),   32'd0);
  endtask

  // Entered and left just after a falling edge.
  task automatic do_word(input logic [7:0] w, input logic m, input int hold, input bit keep);
    int n;
    int ser_cnt;
    logic [31:0] exp;
    in_word   = w;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
`ifdef TWOS_COMP_EN
    mode8 = m;
`endif
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_ready", 32'(in_ready), 32'd1);
    sb.push_back(32'(model8(w, m)));
    @(posedge clk);
    @(negedge clk);
    if (!keep)
      in_valid = 1'b0;
    n = 0;
    ser_cnt = 0;
    while (!out_valid && n < 100) begin
      ser_cnt += int'(ser_en);
      if (keep)
        check_eq("no_accept_in_shift", 32'(in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check_eq("latency8", 32'(n), 32'd8);
    check_eq("ser_en_cycles", 32'(ser_cnt), 32'd8);
    exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check_eq("out_word8", 32'(out_word), exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_word  = 8'h33;
      @(negedge clk);
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      check_eq("bp_out_word",  32'(out_word),  exp);
      check_eq("bp_in_ready",  32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_hs_in_ready",  32'(in_ready),  32'd1);
    check_eq("post_hs_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_hs_hold_word", 32'(out_word),  exp);
  endtask

  task automatic run_narrow(input logic [31:0] w, input bit wide);
    int n;
    logic [31:0] exp;
    if (wide) begin
      w32_word = w; w32_valid = 1'b1;
      sb.push_back(~w);
    end else begin
      w2_word = w[1:0]; w2_valid = 1'b1;
      sb.push_back({30'd0, ~w[1:0]});
    end
    n = 0;
    while (!(wide ? w32_ready : w2_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq(wide ? "w32_accept" : "w2_accept", 32'(wide ? w32_ready : w2_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    w2_valid  = 1'b0;
    w32_valid = 1'b0;
    n = 0;
    while (!(wide ? w32_ov : w2_ov) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq(wide ? "w32_latency" : "w2_latency", 32'(n), wide ? 32'd32 : 32'd2);
    exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check_eq(wide ? "w32_out_word" : "w2_out_word", wide ? w32_out : {30'd0, w2_out}, exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #12;
    check_reset_outs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_word(8'hA5, 1'b0, 0, 1'b0);
`ifdef TWOS_COMP_EN
    do_word(8'h01, 1'b1, 0, 1'b0);
    do_word(8'h80, 1'b1, 0, 1'b0);
    do_word(8'h00, 1'b1, 0, 1'b0);
    do_word(8'h0C, 1'b1, 0, 1'b0);
    do_word(8'h0C, 1'b0, 0, 1'b0);
`endif
    do_word(8'h96, 1'b0, 20, 1'b0);
    do_word(8'h33, 1'b0, 0, 1'b0);
    do_word(8'hFF, 1'b0, 0, 1'b1);

    in_word  = 8'h5A;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("mid_shift_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outs("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_word(8'h3C, 1'b0, 0, 1'b0);

    run_narrow(32'h3, 1'b0);
    run_narrow(32'hFFFF_FFFF, 1'b1);
    run_narrow(32'h0000_FFFF, 1'b1);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
